// File: rtl/logo_key_gen.sv
// Logo blend-key generator: pixel position counters, logo window gating and a
// frame-synchronous fade envelope feeding a 2-stage alpha x level multiply.
module logo_key_gen #(
  parameter int H_START   = 16,
  parameter int V_START   = 8,
  parameter int LOGO_W    = 64,
  parameter int LOGO_H    = 32,
  parameter int FADE_STEP = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic       pix_valid,
  input  logic [9:0] logo_alpha,
  input  logic       logo_show,
  output logic [9:0] key_out,
  output logic       key_valid,
  output logic       fade_done,
  output logic [1:0] dbg_state,
  output logic [9:0] dbg_level
);

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    FADE_IN  = 2'd1,
    SHOWN    = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_e;

  localparam logic [10:0] STEP    = 11'(FADE_STEP);
  localparam logic [10:0] LVL_MAX = 11'd1023;
  localparam logic [12:0] H_LO    = 13'(H_START);
  localparam logic [12:0] H_HI    = 13'(H_START + LOGO_W);
  localparam logic [12:0] V_LO    = 13'(V_START);
  localparam logic [12:0] V_HI    = 13'(V_START + LOGO_H);

  fade_state_e state_q, state_d;
  logic [9:0]  level_q, level_d;
  logic        fade_done_q, fade_done_d;
  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [11:0] col, line;
  logic        in_window;
  logic        pv_s1_q, win_s1_q;
  logic [9:0]  alpha_s1_q;
  logic        key_valid_q;
  logic [9:0]  key_out_q, key_d;
  logic [10:0] lvl_up;
  logic [9:0]  up_val, dn_val, step_val, shown_dn_val;
  logic        up_full, dn_zero;
  logic [19:0] prod;

  // The pixel's position accounts for a line_start/frame_start in the same cycle.
  always_comb begin
    col = line_start ? 12'd0 : h_cnt_q;
    if (line_start) line = frame_start ? 12'd0 : v_cnt_q + 12'd1;
    else            line = v_cnt_q;
    h_cnt_d = line_start ? 12'd0 : h_cnt_q;
    if (pix_valid) h_cnt_d = col + 12'd1;
    if (line_start)       v_cnt_d = line;
    else if (frame_start) v_cnt_d = 12'hFFF;
    else                  v_cnt_d = v_cnt_q;
    in_window = ({1'b0, col} >= H_LO) && ({1'b0, col} < H_HI) &&
                ({1'b0, line} >= V_LO) && ({1'b0, line} < V_HI);
  end

  always_comb begin
    lvl_up       = {1'b0, level_q} + STEP;
    up_full      = (lvl_up >= LVL_MAX);
    up_val       = up_full ? 10'd1023 : lvl_up[9:0];
    dn_zero      = ({1'b0, level_q} <= STEP);
    dn_val       = dn_zero ? 10'd0 : 10'({1'b0, level_q} - STEP);
    step_val     = (STEP >= LVL_MAX) ? 10'd1023 : STEP[9:0];
    shown_dn_val = (STEP >= LVL_MAX) ? 10'd0 : 10'(LVL_MAX - STEP);
  end

  // Fade envelope advances only on frame_start so a frame sees one level.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (frame_start) begin
      case (state_q)
        HIDDEN: if (logo_show) begin
          state_d = FADE_IN;
          level_d = step_val;
        end
        FADE_IN: if (!logo_show) begin
          state_d = FADE_OUT;
          level_d = dn_val;
        end else begin
          level_d = up_val;
          if (up_full) state_d = SHOWN;
        end
        SHOWN: if (!logo_show) begin
          state_d = FADE_OUT;
          level_d = shown_dn_val;
        end
        FADE_OUT: if (logo_show) begin
          state_d = FADE_IN;
          level_d = up_val;
        end else begin
          level_d = dn_val;
          if (dn_zero) state_d = HIDDEN;
        end
        default: state_d = HIDDEN;
      endcase
    end
    fade_done_d = frame_start && (state_d != state_q) &&
                  ((state_d == SHOWN) || (state_d == HIDDEN));
  end

  always_comb begin
    prod  = 20'(alpha_s1_q) * 20'(level_q);
    key_d = (pv_s1_q && win_s1_q) ? 10'(prod >> 10) : 10'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HIDDEN;
      level_q     <= 10'd0;
      fade_done_q <= 1'b0;
      h_cnt_q     <= 12'd0;
      v_cnt_q     <= 12'hFFF;
      pv_s1_q     <= 1'b0;
      win_s1_q    <= 1'b0;
      alpha_s1_q  <= 10'd0;
      key_valid_q <= 1'b0;
      key_out_q   <= 10'd0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      fade_done_q <= fade_done_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      pv_s1_q     <= pix_valid;
      win_s1_q    <= in_window;
      alpha_s1_q  <= logo_alpha;
      key_valid_q <= pv_s1_q;
      key_out_q   <= key_d;
    end
  end

  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign fade_done = fade_done_q;
  assign dbg_state = state_q;
  assign dbg_level = level_q;

endmodule

// File: tb/tb_logo_key_gen.sv
// Directed bench for logo_key_gen: table of per-frame fade steps with a pixel
// scoreboard, plus hand sequences for latency and mid-window reset.
module tb_logo_key_gen;

  localparam int ST_HID = 0;
  localparam int ST_FI  = 1;
  localparam int ST_SH  = 2;
  localparam int ST_FO  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       line_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [9:0] logo_alpha = 10'd0;
  logic       logo_show = 1'b0;
  logic [9:0] key_out;
  logic       key_valid;
  logic       fade_done;
  logic [1:0] dbg_state;
  logic [9:0] dbg_level;

  logo_key_gen dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .pix_valid(pix_valid), .logo_alpha(logo_alpha), .logo_show(logo_show),
    .key_out(key_out), .key_valid(key_valid), .fade_done(fade_done),
    .dbg_state(dbg_state), .dbg_level(dbg_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic do_reset;
    logic show;
    logic fs_ls;
    logic pix_ls;
    int   nlines;
    int   ncols;
    int   alpha;
    int   exp_level;
    int   exp_state;
    logic exp_done;
    int   hand;
  } row_t;

  row_t       tbl[18];
  logic [9:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         exp_done_cnt = 0;
  logic       mon_en = 1'b0;
  int         m_h = 0;
  int         m_v = 4095;
  int         m_level = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && key_valid) begin
      check("key_valid_has_expectation", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("key_out", int'(key_out), int'(exp_q.pop_front()));
    end
    if (fade_done) done_cnt++;
  end

  // Drive one cycle and model the pixel's position and expected key.
  task automatic drive(input logic fs, input logic ls, input logic pv, input int a);
    bit win;
    frame_start = fs;
    line_start  = ls;
    pix_valid   = pv;
    logo_alpha  = 10'(a);
    if (ls) begin
      m_h = 0;
      m_v = fs ? 0 : (m_v + 1) % 4096;
    end else if (fs) begin
      m_v = 4095;
    end
    if (pv) begin
      win = (m_h >= 16) && (m_h < 80) && (m_v >= 8) && (m_v < 40);
      exp_q.push_back(win ? 10'((a * m_level) >> 10) : 10'd0);
      m_h++;
    end
    @(posedge clk); #1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    pix_valid   = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    exp_q.delete();
    m_h = 0;
    m_v = 4095;
    m_level = 0;
    mon_en = 1'b1;
  endtask

  task automatic run_row(input row_t r);
    logo_show = r.show;
    drive(1'b1, r.fs_ls, 1'b0, 0);
    check("fade_done_at_step", int'(fade_done), int'(r.exp_done));
    check("fade_level", int'(dbg_level), r.exp_level);
    check("fade_state", int'(dbg_state), r.exp_state);
    m_level = r.exp_level;
    drive(1'b0, 1'b0, 1'b0, 0);
    for (int l = 0; l < r.nlines; l++) begin
      if (!(l == 0 && r.fs_ls) && !r.pix_ls) drive(1'b0, 1'b1, 1'b0, 0);
      for (int c = 0; c < r.ncols; c++)
        drive(1'b0, (c == 0) && r.pix_ls && !(l == 0 && r.fs_ls), 1'b1, r.alpha);
      drive(1'b0, 1'b0, 1'b0, 0);
      drive(1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  task automatic goto_line8_col(input int last_col);
    for (int l = 0; l < 9; l++) drive(1'b0, 1'b1, 1'b0, 0);
    for (int c = 0; c <= last_col; c++) drive(1'b0, 1'b0, 1'b1, 1023);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 20, 1023, 0,    ST_HID, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 20, 1023, 0,    ST_HID, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 20, 1023, 0,    ST_HID, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 20, 1023, 256,  ST_FI,  1'b0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 20, 1023, 512,  ST_FI,  1'b0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 20, 1023, 768,  ST_FI,  1'b0, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  20, 1023, 1023, ST_SH,  1'b1, 1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 42, 82, 1023, 1023, ST_SH,  1'b0, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10, 20, 500,  1023, ST_SH,  1'b0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 20, 1023, 767,  ST_FO,  1'b0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 20, 1023, 1023, ST_FI,  1'b0, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  20, 1023, 1023, ST_SH,  1'b1, 2};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 20, 1023, 0,    ST_HID, 1'b0, 0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 20, 1023, 256,  ST_FI,  1'b0, 0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 20, 600,  256,  ST_FI,  1'b0, 0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 20, 600,  512,  ST_FI,  1'b0, 0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 20, 600,  256,  ST_FO,  1'b0, 0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 20, 600,  0,    ST_HID, 1'b1, 0};

    do_reset();
    check("reset_key_out", int'(key_out), 0);
    check("reset_key_valid", int'(key_valid), 0);
    check("reset_fade_done", int'(fade_done), 0);
    check("reset_state", int'(dbg_state), ST_HID);
    check("reset_level", int'(dbg_level), 0);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].do_reset) do_reset();
      run_row(tbl[i]);
      exp_done_cnt += int'(tbl[i].exp_done);
      if (tbl[i].hand == 1) begin
        // Pixel (16,8) must emerge exactly two cycles after it is presented.
        goto_line8_col(15);
        drive(1'b0, 1'b0, 1'b1, 1023);
        check("lat_col15_valid", int'(key_valid), 1);
        check("lat_col15_key", int'(key_out), 0);
        drive(1'b0, 1'b0, 1'b0, 0);
        check("lat_col16_valid", int'(key_valid), 1);
        check("lat_col16_key", int'(key_out), 1022);
        drive(1'b0, 1'b0, 1'b0, 0);
        check("lat_tail_valid", int'(key_valid), 0);
        drive(1'b0, 1'b0, 1'b0, 0);
      end else if (tbl[i].hand == 2) begin
        goto_line8_col(20);
        check("pre_reset_valid", int'(key_valid), 1);
        check("pre_reset_key", int'(key_out), 1022);
        mon_en = 1'b0;
        reset = 1'b1;
        pix_valid = 1'b1;
        logo_alpha = 10'd1023;
        @(posedge clk); #1;
        check("mid_reset_key_valid", int'(key_valid), 0);
        check("mid_reset_key_out", int'(key_out), 0);
        check("mid_reset_state", int'(dbg_state), ST_HID);
        check("mid_reset_level", int'(dbg_level), 0);
        pix_valid = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        m_h = 0;
        m_v = 4095;
        m_level = 0;
        drive(1'b0, 1'b0, 1'b0, 0);
        check("post_reset_key_valid", int'(key_valid), 0);
        mon_en = 1'b1;
      end
      check("queue_drained", exp_q.size(), 0);
      check("fade_done_count", done_cnt, exp_done_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
